// File: rtl/shift_share_ctrl_pkg.sv
// shift_share_ctrl_pkg: shared opcode, FSM state and port encodings for the shift-share controller
package shift_share_ctrl_pkg;
  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/shift_share_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin grant (req_i/gnt_o bit0 = A, bit1 = B), last grant updated when en_i sees a request
module rr_arb2
  import shift_share_ctrl_pkg::*;
#(
  parameter logic FIRST_PRI = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);
  logic last_q;
  assign gnt_o[0] = req_i[0] && (!req_i[1] || last_q == PORT_B);
  assign gnt_o[1] = req_i[1] && !gnt_o[0];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_q <= ~FIRST_PRI;
    else if (en_i && |req_i) last_q <= gnt_o[1];
  end
endmodule

// File: rtl/shift_share_ctrl.sv
// shift_share_ctrl: shares one 32-bit SLL/SRA shifter between request ports A and B with held responses on rsp_data
module shift_share_ctrl
  import shift_share_ctrl_pkg::*;
#(
  parameter int   DATA_W    = 32,
  parameter int   SHAMT_W   = 5,
  parameter logic FIRST_PRI = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [DATA_W-1:0]  a_data,
  input  logic [SHAMT_W-1:0] a_shamt,
  input  logic               a_op,
  output logic               a_rsp_valid,
  input  logic               a_rsp_ready,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [DATA_W-1:0]  b_data,
  input  logic [SHAMT_W-1:0] b_shamt,
  input  logic               b_op,
  output logic               b_rsp_valid,
  input  logic               b_rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               busy
);
  logic [1:0]         state_q, state_d;
  logic               owner_q, op_q;
  logic [DATA_W-1:0]  data_q, rsp_q, sra, sll;
  logic [SHAMT_W-1:0] shamt_q;
  logic [1:0]         gnt;
  logic               own_rdy, offer, hs;
  assign own_rdy = owner_q == PORT_B ? b_rsp_ready : a_rsp_ready;
  assign offer   = state_q == ST_IDLE || (state_q == ST_DONE && own_rdy);
  assign hs      = offer && (a_valid || b_valid);
  rr_arb2 #(.FIRST_PRI(FIRST_PRI)) u_arb (
    .clock (clock),
    .reset (reset),
    .req_i ({b_valid, a_valid}),
    .en_i  (offer),
    .gnt_o (gnt)
  );
  assign a_ready = offer && gnt[0];
  assign b_ready = offer && gnt[1];
  assign sra = $unsigned($signed(data_q) >>> shamt_q);
  assign sll = data_q << shamt_q;
  always_comb begin
    state_d = state_q == ST_BUSY ? ST_DONE :
              (state_q == ST_DONE && !own_rdy) ? ST_DONE :
              hs ? ST_BUSY : ST_IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_A;
      op_q    <= OP_SLL;
      data_q  <= '0;
      shamt_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        owner_q <= gnt[1];
        op_q    <= gnt[1] ? b_op : a_op;
        data_q  <= gnt[1] ? b_data : a_data;
        shamt_q <= gnt[1] ? b_shamt : a_shamt;
      end
      if (state_q == ST_BUSY) rsp_q <= op_q == OP_SRA ? sra : sll;
    end
  end
  assign a_rsp_valid = state_q == ST_DONE && owner_q == PORT_A;
  assign b_rsp_valid = state_q == ST_DONE && owner_q == PORT_B;
  assign rsp_data    = rsp_q;
  assign busy        = state_q != ST_IDLE;
endmodule
